// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core load/store port. Accepts
//               word-aligned read/write requests over valid/ready, inserts
//               WAIT_CYCLES wait states, then returns read data or an error
//               over a second valid/ready handshake.
//               Optional feature macro: DMEM_TOHOST_EN (simulation-exit mailbox
//               at TOHOST_ADDR driving sim_done_o / sim_code_o).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        sim_done_o,
  output logic [31:0] sim_code_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // One past the last valid byte address, kept 33 bits wide so it never wraps.
  localparam logic [32:0] C_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  localparam logic [CNT_W-1:0] C_CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  // Request decode (combinational, valid while a request is offered)
  logic [31:0]      offset_d;
  logic [IDX_W-1:0] idx_d;
  logic             in_range_d;
  logic             misalign_d;
  logic             tohost_d;
  logic             err_d;
  logic             accept_d;
  logic             unused_d;

  assign offset_d   = req_addr_i - BASE_ADDR;
  assign idx_d      = offset_d[IDX_W+1:2];
  assign in_range_d = ({1'b0, req_addr_i} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, req_addr_i} < C_LIMIT);
  assign misalign_d = |req_addr_i[1:0];
  assign err_d      = (misalign_d || !in_range_d) && !tohost_d;
  // rst gate keeps the array untouched on an edge seen while reset is held.
  assign accept_d   = req_valid_i && req_ready_q && !rst;

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef DMEM_TOHOST_EN
  logic        sim_done_q;
  logic [31:0] sim_code_q;

  assign tohost_d   = req_we_i && (req_addr_i == TOHOST_ADDR);
  assign sim_done_o = sim_done_q;
  assign sim_code_o = sim_code_q;
  assign unused_d   = ^{offset_d[31:IDX_W+2], offset_d[1:0]};

  // Mailbox: sticky done flag, code follows the latest mailbox write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_done_q <= 1'b0;
      sim_code_q <= 32'h0;
    end else if (accept_d && tohost_d) begin
      sim_done_q <= 1'b1;
      sim_code_q <= req_wdata_i;
    end
  end
`else
  assign tohost_d   = 1'b0;
  assign sim_done_o = 1'b0;
  assign sim_code_o = 32'h0;
  assign unused_d   = ^{offset_d[31:IDX_W+2], offset_d[1:0], TOHOST_ADDR};
`endif

  // Backing array: byte-enabled write committed at the accept edge
  always_ff @(posedge clk) begin
    if (accept_d && req_we_i && !err_d && !tohost_d) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be_i[b]) begin
          mem_q[idx_d][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Request/response FSM; rsp_valid rises one cycle after RESP is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            err_q       <= err_d;
            idx_q       <= idx_d;
            if (WAIT_CYCLES == 0) begin
              // No wait states: the array is sampled on this same edge.
              state_q     <= ST_RESP;
              rsp_rdata_q <= (req_we_i || err_d) ? 32'h0 : mem_q[idx_d];
              rsp_err_q   <= err_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= C_CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_rdata_q <= (we_q || err_q) ? 32'h0 : mem_q[idx_q];
            rsp_err_q   <= err_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder. Stimulus pushes expected
//               responses into a queue; a monitor pops and compares on every
//               response handshake. Honors DMEM_TOHOST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int C_LAT = 3;   // edges from accept to rsp_valid with WAIT_CYCLES=2

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sim_done;
  logic [31:0] sim_code;

  int checks;
  int failures;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];

  dmem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .sim_done_o  (sim_done),
    .sim_code_o  (sim_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every response handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_rdata_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
          check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err_q.pop_front()});
        end
      end
    end
  end

  // Offer one request and return #1 after the accepting edge
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<50", t);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count edges until rsp_valid rises; returns after it is seen
  task automatic wait_rsp;
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, C_LAT);
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while (!(req_ready && !rsp_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=%0d required=<100", t);
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_e);
    issue(we, addr, wdata, be);
    exp_rdata_q.push_back(exp_rd);
    exp_err_q.push_back(exp_e);
    wait_rsp();
    wait_idle();
  endtask

  initial begin
    logic [31:0] held;
    logic        stable_ok;
    logic        ready_low_ok;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_sim_done", {31'h0, sim_done}, 32'h0);
    check("rst_sim_code", sim_code, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read
    txn(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    // Byte lanes and be=0 no-op
    txn(1'b1, 32'h0000_2004, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    txn(1'b1, 32'h0000_2004, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    txn(1'b1, 32'h0000_2004, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    txn(1'b0, 32'h0000_2004, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);

    // Errors and range boundaries
    txn(1'b0, 32'h0000_2002, 32'h0, 4'hF, 32'h0, 1'b1);
    txn(1'b1, 32'h0000_2FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    txn(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    txn(1'b0, 32'h0000_2FFC, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
    txn(1'b0, 32'h0000_1FFC, 32'h0, 4'hF, 32'h0, 1'b1);
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1);
    txn(1'b1, 32'h0000_2001, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1);
    txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    // Backpressure: hold rsp_ready low for 10 cycles
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_2004, 32'h0, 4'hF);
    exp_rdata_q.push_back(32'h11BB_33DD);
    exp_err_q.push_back(1'b0);
    wait_rsp();
    held         = rsp_rdata;
    stable_ok    = 1'b1;
    ready_low_ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_rdata !== held || rsp_err !== 1'b0) stable_ok = 1'b0;
      if (req_ready !== 1'b0) ready_low_ok = 1'b0;
    end
    check("bp_stable", {31'h0, stable_ok}, 32'h1);
    check("bp_req_ready_low", {31'h0, ready_low_ok}, 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", {31'h0, rsp_valid}, 32'h0);
    check("bp_req_ready_back", {31'h0, req_ready}, 32'h1);

    // Asynchronous reset in WAIT: write stays committed, response dropped
    issue(1'b1, 32'h0000_2008, 32'h5555_5555, 4'hF);
    check("wait_req_ready", {31'h0, req_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async_req_ready", {31'h0, req_ready}, 32'h1);
    check("async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("held_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h0000_2008, 32'h0, 4'hF, 32'h5555_5555, 1'b0);

    // Mailbox
`ifdef DMEM_TOHOST_EN
    txn(1'b1, 32'h0000_1000, 32'h0000_0001, 4'h0, 32'h0, 1'b0);
    check("tohost_done", {31'h0, sim_done}, 32'h1);
    check("tohost_code", sim_code, 32'h1);
    txn(1'b1, 32'h0000_1000, 32'h0000_0007, 4'hF, 32'h0, 1'b0);
    check("tohost_done2", {31'h0, sim_done}, 32'h1);
    check("tohost_code2", sim_code, 32'h7);
`else
    txn(1'b1, 32'h0000_1000, 32'h0000_0001, 4'hF, 32'h0, 1'b1);
    check("tohost_done", {31'h0, sim_done}, 32'h0);
    check("tohost_code", sim_code, 32'h0);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_rdata_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
